// File: rtl/huffman_mcu_scheduler.sv
// Feeds one MCU's zigzag blocks (NY x Y, Cb, Cr) to the Huffman encoder controller,
// tracking per-component DC predictors and inserting restart points every RST_INTERVAL MCUs.
module huffman_mcu_scheduler #(
  parameter int COEF_W       = 8,
  parameter int NY           = 4,
  parameter int RST_INTERVAL = 0,
  parameter int DONE_TIMEOUT = 1024
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     blk_valid,
  output logic                     blk_ready,
  input  logic [1:0]               blk_comp,
  input  logic [64*COEF_W-1:0]     blk_data,
  output logic                     huff_start,
  output logic [64*COEF_W-1:0]     huff_matrix,
  output logic signed [COEF_W:0]   huff_dc_diff,
  output logic                     huff_table_sel,
  input  logic                     huff_done,
  output logic                     rst_marker,
  output logic [2:0]               rst_num,
  output logic                     busy,
  output logic                     seq_err,
  output logic                     timeout_err,
  input  logic                     err_clr
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] ADVANCE   = 3'd4;
  localparam logic [2:0] RST_MARK  = 3'd5;

  localparam int              TO_W     = $clog2(DONE_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(DONE_TIMEOUT - 1);
  localparam logic [2:0]      NY_IDX   = 3'(NY);
  localparam logic [2:0]      LAST_IDX = 3'(NY + 1);
  localparam logic [15:0]     RST_L    = 16'(RST_INTERVAL);

  logic [2:0]              state, state_next;
  logic [2:0]              blk_idx;
  logic [15:0]             mcu_cnt;
  logic [TO_W-1:0]         to_cnt;
  logic [64*COEF_W-1:0]    data_q;
  logic [1:0]              comp_q;
  logic [COEF_W-1:0]       pred_y, pred_cb, pred_cr, pred_sel;
  logic [1:0]              exp_comp;
  logic                    xfer, comp_ok, last_blk, restart_due;
  logic                    seq_set, timeout_set;

  always_comb begin
    exp_comp = 2'd2;
    if (blk_idx < NY_IDX)
      exp_comp = 2'd0;
    else if (blk_idx == NY_IDX)
      exp_comp = 2'd1;
  end

  always_comb begin
    pred_sel = pred_y;
    if (comp_q == 2'd1)
      pred_sel = pred_cb;
    else if (comp_q == 2'd2)
      pred_sel = pred_cr;
  end

  assign xfer        = blk_valid & blk_ready;
  assign comp_ok     = (blk_comp == exp_comp);
  assign last_blk    = (blk_idx == LAST_IDX);
  assign restart_due = (RST_INTERVAL != 0) && last_blk && ((mcu_cnt + 16'd1) == RST_L);
  assign seq_set     = (state == IDLE) && xfer && !comp_ok;
  assign timeout_set = (state == WAIT_DONE) && !huff_done && (to_cnt == TO_LAST);
  assign busy        = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (xfer && comp_ok) state_next = LOAD;
      LOAD:      state_next = START;
      START:     state_next = WAIT_DONE;
      WAIT_DONE: if (huff_done || to_cnt == TO_LAST) state_next = ADVANCE;
      ADVANCE:   state_next = restart_due ? RST_MARK : IDLE;
      RST_MARK:  state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up exactly with the state they mark.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      blk_ready      <= 1'b0;
      huff_start     <= 1'b0;
      rst_marker     <= 1'b0;
      huff_matrix    <= '0;
      huff_dc_diff   <= '0;
      huff_table_sel <= 1'b0;
      rst_num        <= 3'd0;
      seq_err        <= 1'b0;
      timeout_err    <= 1'b0;
      blk_idx        <= 3'd0;
      mcu_cnt        <= 16'd0;
      to_cnt         <= '0;
      data_q         <= '0;
      comp_q         <= 2'd0;
      pred_y         <= '0;
      pred_cb        <= '0;
      pred_cr        <= '0;
    end else begin
      state       <= state_next;
      blk_ready   <= (state_next == IDLE);
      huff_start  <= (state_next == START);
      rst_marker  <= (state_next == RST_MARK);
      seq_err     <= seq_set     | (seq_err     & ~err_clr);
      timeout_err <= timeout_set | (timeout_err & ~err_clr);
      case (state)
        IDLE: begin
          if (xfer && comp_ok) begin
            data_q <= blk_data;
            comp_q <= blk_comp;
          end
        end
        LOAD: begin
          huff_matrix    <= data_q;
          huff_dc_diff   <= {data_q[COEF_W-1], data_q[COEF_W-1:0]} - {pred_sel[COEF_W-1], pred_sel};
          huff_table_sel <= (comp_q != 2'd0);
          case (comp_q)
            2'd1:    pred_cb <= data_q[COEF_W-1:0];
            2'd2:    pred_cr <= data_q[COEF_W-1:0];
            default: pred_y  <= data_q[COEF_W-1:0];
          endcase
        end
        START:     to_cnt <= '0;
        WAIT_DONE: to_cnt <= to_cnt + TO_W'(1);
        ADVANCE: begin
          if (last_blk) begin
            blk_idx <= 3'd0;
            mcu_cnt <= mcu_cnt + 16'd1;
          end else begin
            blk_idx <= blk_idx + 3'd1;
          end
        end
        RST_MARK: begin
          pred_y  <= '0;
          pred_cb <= '0;
          pred_cr <= '0;
          mcu_cnt <= 16'd0;
          rst_num <= rst_num + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_mcu_scheduler.sv
// Randomised bench for huffman_mcu_scheduler; expectations come from a component-sequence
// and DC-predictor model kept in the bench.
module tb_huffman_mcu_scheduler;

  localparam int COEF_W       = 8;
  localparam int NY           = 1;
  localparam int RST_INTERVAL = 2;
  localparam int DONE_TIMEOUT = 16;
  localparam int MW           = 64 * COEF_W;

  logic                   clock, reset_n;
  logic                   blk_valid, blk_ready;
  logic [1:0]             blk_comp;
  logic [MW-1:0]          blk_data;
  logic                   huff_start;
  logic [MW-1:0]          huff_matrix;
  logic signed [COEF_W:0] huff_dc_diff;
  logic                   huff_table_sel, huff_done;
  logic                   rst_marker;
  logic [2:0]             rst_num;
  logic                   busy, seq_err, timeout_err, err_clr;

  huffman_mcu_scheduler #(
    .COEF_W(COEF_W), .NY(NY), .RST_INTERVAL(RST_INTERVAL), .DONE_TIMEOUT(DONE_TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_comp(blk_comp), .blk_data(blk_data),
    .huff_start(huff_start), .huff_matrix(huff_matrix), .huff_dc_diff(huff_dc_diff),
    .huff_table_sel(huff_table_sel), .huff_done(huff_done),
    .rst_marker(rst_marker), .rst_num(rst_num), .busy(busy),
    .seq_err(seq_err), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: MCU component order as a list, predictors indexed by component.
  int seq_tbl[$];
  int m_pred[3];
  int m_pos, m_mcu, m_rst_num;
  bit m_seq_err, m_to_err;
  bit clr_on_xfer;

  task automatic checkOutput(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void modelReset();
    for (int c = 0; c < 3; c++) m_pred[c] = 0;
    m_pos = 0; m_mcu = 0; m_rst_num = 0;
    m_seq_err = 0; m_to_err = 0;
  endfunction

  // done_delay >= 1: cycles after huff_start before huff_done; -1: never (timeout); -2: reset mid-wait.
  task automatic applyStimulus(input logic [1:0] comp, input int coef0, input int done_delay);
    logic [MW-1:0]     data;
    logic [COEF_W:0]   exp_diff;
    int                wait_cyc, cyc;
    bit                seen, exp_marker;
    logic [2:0]        seen_num, exp_num;
    for (int k = 0; k < 64; k++) data[k*COEF_W +: COEF_W] = COEF_W'($urandom);
    data[COEF_W-1:0] = COEF_W'(coef0);
    wait_cyc = 0;
    while (blk_ready !== 1'b1 && wait_cyc < 50) begin
      @(negedge clock);
      wait_cyc++;
    end
    if (blk_ready !== 1'b1) begin
      checkOutput("ready_wait", {7'd0, blk_ready}, 1);
      return;
    end
    blk_valid = 1'b1; blk_comp = comp; blk_data = data; err_clr = clr_on_xfer;
    @(negedge clock);
    blk_valid = 1'b0; err_clr = 1'b0;
    if (clr_on_xfer) begin
      m_seq_err = 0;
      m_to_err  = 0;
    end
    if (int'(comp) != seq_tbl[m_pos]) begin
      m_seq_err = 1;
      checkOutput("seq_err_set", seq_err, 1);
      checkOutput("ready_after_bad", blk_ready, 1);
      checkOutput("timeout_err_bad", timeout_err, m_to_err);
      for (int i = 0; i < 3; i++) begin
        checkOutput("no_start", huff_start, 0);
        @(negedge clock);
      end
      return;
    end
    checkOutput("start_early", huff_start, 0);
    @(negedge clock);
    checkOutput("start_latency", huff_start, 1);
    exp_diff = COEF_W'(0) + (coef0 - m_pred[comp]);
    m_pred[comp] = coef0;
    checkOutput("matrix", huff_matrix, data);
    checkOutput("dc_diff", $unsigned(huff_dc_diff), exp_diff);
    checkOutput("table_sel", huff_table_sel, (comp != 2'd0));
    checkOutput("busy_run", busy, 1);
    if (done_delay == -2) begin
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      checkOutput("rst_ready", blk_ready, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_diff", $unsigned(huff_dc_diff), 0);
      checkOutput("rst_seq_err", seq_err, 0);
      @(negedge clock);
      reset_n = 1'b1;
      modelReset();
      return;
    end else if (done_delay == -1) begin
      err_clr = 1'b1;
      cyc = 0;
      do begin
        @(negedge clock);
        err_clr = 1'b0;
        cyc++;
      end while (timeout_err !== 1'b1 && cyc < 100);
      m_seq_err = 0;
      m_to_err  = 1;
      checkOutput("timeout_latency", cyc, DONE_TIMEOUT + 1);
    end else begin
      repeat (done_delay) @(negedge clock);
      huff_done = 1'b1;
      @(negedge clock);
      huff_done = 1'b0;
    end
    m_pos++;
    exp_marker = 0;
    exp_num    = 3'd0;
    if (m_pos == seq_tbl.size()) begin
      m_pos = 0;
      m_mcu++;
      if (m_mcu == RST_INTERVAL) begin
        exp_marker = 1;
        exp_num    = 3'(m_rst_num);
        for (int c = 0; c < 3; c++) m_pred[c] = 0;
        m_mcu     = 0;
        m_rst_num = (m_rst_num + 1) % 8;
      end
    end
    seen = 0; seen_num = 3'd0; cyc = 0;
    while (busy === 1'b1 && cyc < 20) begin
      if (rst_marker === 1'b1) begin
        seen = 1;
        seen_num = rst_num;
      end
      @(negedge clock);
      cyc++;
    end
    checkOutput("busy_idle", busy, 0);
    checkOutput("ready_idle", blk_ready, 1);
    checkOutput("rst_marker", seen, exp_marker);
    if (exp_marker) checkOutput("rst_num", seen_num, exp_num);
    checkOutput("seq_err", seq_err, m_seq_err);
    checkOutput("timeout_err", timeout_err, m_to_err);
  endtask

  initial begin
    int r, cmp, dly;
    logic [1:0] rc;
    for (int i = 0; i < NY; i++) seq_tbl.push_back(0);
    seq_tbl.push_back(1);
    seq_tbl.push_back(2);
    reset_n = 1'b0; blk_valid = 1'b0; blk_comp = 2'd0; blk_data = '0;
    huff_done = 1'b0; err_clr = 1'b0; clr_on_xfer = 1'b0;
    modelReset();
    repeat (3) @(negedge clock);
    checkOutput("reset_ready", blk_ready, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_start", huff_start, 0);
    checkOutput("reset_marker", rst_marker, 0);
    checkOutput("reset_rst_num", rst_num, 0);
    checkOutput("reset_errs", {seq_err, timeout_err}, 0);
    checkOutput("reset_diff", $unsigned(huff_dc_diff), 0);
    reset_n = 1'b1;

    applyStimulus(2'd0, 10, 1);  checkOutput("t1_y10", $unsigned(huff_dc_diff), 9'd10);
    applyStimulus(2'd1, 5, 2);   checkOutput("t1_cb", $unsigned(huff_dc_diff), 9'd5);
    applyStimulus(2'd2, -3, 1);  checkOutput("t1_cr", $unsigned(huff_dc_diff), 9'h1FD);
    applyStimulus(2'd0, 15, 3);  checkOutput("t1_y15", $unsigned(huff_dc_diff), 9'd5);
    applyStimulus(2'd1, 5, 1);
    applyStimulus(2'd2, -3, 1);
    applyStimulus(2'd0, 127, 1); checkOutput("t3_raw", $unsigned(huff_dc_diff), 9'd127);
    applyStimulus(2'd1, 1, 1);
    applyStimulus(2'd2, 2, 1);
    applyStimulus(2'd0, -128, 2); checkOutput("t2_minmax", $unsigned(huff_dc_diff), 9'h101);
    applyStimulus(2'd1, 4, 1);
    applyStimulus(2'd2, 4, 1);

    clr_on_xfer = 1'b1;
    applyStimulus(2'd1, 7, 1);
    clr_on_xfer = 1'b0;
    applyStimulus(2'd0, 20, 1);  checkOutput("t4_y_after_bad", $unsigned(huff_dc_diff), 9'd20);
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    m_seq_err = 0;
    checkOutput("t4_err_clr", seq_err, 0);

    applyStimulus(2'd1, 3, -1);
    applyStimulus(2'd2, 9, 1);
    applyStimulus(2'd0, 50, -2);
    applyStimulus(2'd0, 33, 1);  checkOutput("t6_after_reset", $unsigned(huff_dc_diff), 9'd33);

    for (int n = 0; n < 90; n++) begin
      r = $urandom_range(0, 9);
      rc = (r == 0) ? 2'($urandom_range(0, 3)) : 2'(seq_tbl[m_pos]);
      cmp = $urandom_range(0, 255) - 128;
      dly = ($urandom_range(0, 19) == 0) ? -1 : $urandom_range(1, 4);
      clr_on_xfer = ($urandom_range(0, 7) == 0);
      applyStimulus(rc, cmp, dly);
    end
    clr_on_xfer = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
